// File: rtl/accum_timer.sv
// Timed accumulator: every PRESCALE enabled RUN clocks, add/subtract STEP into Q (wrap or saturate) until Q hits LIMIT.
// Latency: Q, CO and TC update on the step edge (registered); BUSY decodes the registered state.
// No backpressure: EN low freezes prescaler phase and accumulator; LOAD and CLR take effect on the next edge.
module accum_timer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1,
    parameter int PSW      = 4
) (
    input  logic             CK,
    input  logic             CLR,
    input  logic             START,
    input  logic             EN,
    input  logic             DIR,
    input  logic             SAT,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LDVAL,
    input  logic [WIDTH-1:0] STEP,
    input  logic [WIDTH-1:0] LIMIT,
    output logic [WIDTH-1:0] Q,
    output logic             CO,
    output logic             TC,
    output logic             BUSY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [PSW-1:0] PLAST = PSW'(PRESCALE - 1);

    state_t           state;
    state_t           state_nxt;
    logic [PSW-1:0]   psc;
    logic             advance;
    logic             step_cyc;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             ovf;
    logic [WIDTH-1:0] q_nxt;
    logic             hit;

    // LOAD steals the cycle: no prescaler advance and no step while loading.
    assign advance  = (state == RUN) && EN && !LOAD;
    assign step_cyc = advance && (psc == PLAST);

    assign sum  = {1'b0, Q} + {1'b0, STEP};
    assign diff = {1'b0, Q} - {1'b0, STEP};
    assign ovf  = DIR ? diff[WIDTH] : sum[WIDTH];

    always_comb begin
        q_nxt = DIR ? diff[WIDTH-1:0] : sum[WIDTH-1:0];
        if (ovf && SAT) begin
            q_nxt = DIR ? '0 : '1;
        end
    end

    assign hit = (q_nxt == LIMIT);

    always_ff @(posedge CK) begin
        if (CLR) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (START) state_nxt = RUN;
            RUN:     if (step_cyc && hit) state_nxt = DONE;
            DONE:    if (START) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state == RUN);
    end

    always_ff @(posedge CK) begin
        if (CLR) begin
            Q   <= '0;
            psc <= '0;
            CO  <= 1'b0;
            TC  <= 1'b0;
        end else begin
            CO <= step_cyc && ovf;
            TC <= step_cyc && hit;
            if (LOAD) begin
                Q   <= LDVAL;
                psc <= '0;
            end else if (advance) begin
                psc <= step_cyc ? '0 : psc + PSW'(1);
                if (step_cyc) begin
                    Q <= q_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_accum_timer.sv
// Directed bench for accum_timer: stimulus queues expected post-edge outputs, a monitor pops and compares each cycle.
module tb_accum_timer;

    logic       CK = 1'b0;
    logic       CLR = 1'b1;
    logic       START = 1'b0;
    logic       EN = 1'b1;
    logic       DIR = 1'b0;
    logic       SAT = 1'b0;
    logic       LOAD = 1'b0;
    logic [7:0] LDVAL = 8'h00;
    logic [7:0] STEP = 8'h00;
    logic [7:0] LIMIT = 8'h00;

    logic [7:0] q1, q4;
    logic       co1, tc1, busy1, co4, tc4, busy4;

    always #5 CK = ~CK;

    accum_timer #(.WIDTH(8), .PRESCALE(1), .PSW(4)) u1 (
        .CK(CK), .CLR(CLR), .START(START), .EN(EN), .DIR(DIR), .SAT(SAT),
        .LOAD(LOAD), .LDVAL(LDVAL), .STEP(STEP), .LIMIT(LIMIT),
        .Q(q1), .CO(co1), .TC(tc1), .BUSY(busy1)
    );

    accum_timer #(.WIDTH(8), .PRESCALE(4), .PSW(4)) u4 (
        .CK(CK), .CLR(CLR), .START(START), .EN(EN), .DIR(DIR), .SAT(SAT),
        .LOAD(LOAD), .LDVAL(LDVAL), .STEP(STEP), .LIMIT(LIMIT),
        .Q(q4), .CO(co4), .TC(tc4), .BUSY(busy4)
    );

    typedef struct packed {
        logic       sel4;
        logic [7:0] q;
        logic       co;
        logic       tc;
        logic       busy;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    // Queue what the selected DUT must show after the coming posedge, then let that edge pass.
    task automatic tick(input string nm, input logic sel4, input logic [7:0] q,
                        input logic co, input logic tc, input logic busy);
        exp_t e;
        e.sel4 = sel4; e.q = q; e.co = co; e.tc = tc; e.busy = busy;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge CK);
    endtask

    always @(posedge CK) begin
        exp_t       e;
        string      nm;
        logic [7:0] aq;
        logic       aco, atc, ab;
        #1;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            aq  = e.sel4 ? q4 : q1;
            aco = e.sel4 ? co4 : co1;
            atc = e.sel4 ? tc4 : tc1;
            ab  = e.sel4 ? busy4 : busy1;
            n_tests++;
            if (aq !== e.q || aco !== e.co || atc !== e.tc || ab !== e.busy) begin
                n_fail++;
                $display("FAIL %s: got q=%h co=%b tc=%b busy=%b, want q=%h co=%b tc=%b busy=%b",
                         nm, aq, aco, atc, ab, e.q, e.co, e.tc, e.busy);
            end
        end
    end

    initial begin
        // Reset and first run to LIMIT
        CLR = 1'b1;
        tick("reset", 0, 8'h00, 0, 0, 0);
        CLR = 1'b0; STEP = 8'd3; LIMIT = 8'd9; START = 1'b1;
        tick("t1_start", 0, 8'd0, 0, 0, 1);
        START = 1'b0;
        tick("t1_q3", 0, 8'd3, 0, 0, 1);
        tick("t1_q6", 0, 8'd6, 0, 0, 1);
        tick("t1_q9_tc", 0, 8'd9, 0, 1, 0);
        tick("t1_hold_a", 0, 8'd9, 0, 0, 0);
        tick("t1_hold_b", 0, 8'd9, 0, 0, 0);

        // Resume from DONE; START in RUN ignored
        LIMIT = 8'd20; STEP = 8'd1; START = 1'b1;
        tick("t6_resume", 0, 8'd9, 0, 0, 1);
        START = 1'b0;
        tick("t6_q10", 0, 8'd10, 0, 0, 1);
        START = 1'b1;
        tick("t6_start_in_run", 0, 8'd11, 0, 0, 1);
        START = 1'b0;
        tick("t6_q12", 0, 8'd12, 0, 0, 1);

        // CLR on a step cycle that would have hit LIMIT
        CLR = 1'b1; LIMIT = 8'd13;
        tick("t5_clr_abort", 0, 8'd0, 0, 0, 0);
        CLR = 1'b0;
        tick("t5_idle", 0, 8'd0, 0, 0, 0);
        LOAD = 1'b1; LDVAL = 8'h40; START = 1'b1; LIMIT = 8'h50;
        tick("t5_load_start", 0, 8'h40, 0, 0, 1);
        LOAD = 1'b0; START = 1'b0;
        tick("t5_q41", 0, 8'h41, 0, 0, 1);
        LOAD = 1'b1; LDVAL = 8'h50;
        tick("t5_load_eq_limit", 0, 8'h50, 0, 0, 1);
        LOAD = 1'b0;
        tick("t5_past_limit", 0, 8'h51, 0, 0, 1);

        // Add overflow: wrap then saturate
        LOAD = 1'b1; LDVAL = 8'hFE; LIMIT = 8'h10; STEP = 8'd5; SAT = 1'b0;
        tick("t3_load_fe", 0, 8'hFE, 0, 0, 1);
        LOAD = 1'b0;
        tick("t3_wrap", 0, 8'h03, 1, 0, 1);
        tick("t3_after_wrap", 0, 8'h08, 0, 0, 1);
        SAT = 1'b1; LOAD = 1'b1;
        tick("t3_reload_fe", 0, 8'hFE, 0, 0, 1);
        LOAD = 1'b0;
        tick("t3_sat", 0, 8'hFF, 1, 0, 1);
        tick("t3_sat_hold_a", 0, 8'hFF, 1, 0, 1);
        tick("t3_sat_hold_b", 0, 8'hFF, 1, 0, 1);

        // Subtract underflow: wrap then saturate
        SAT = 1'b0; DIR = 1'b1; STEP = 8'd3; LOAD = 1'b1; LDVAL = 8'h02;
        tick("t4_load_02", 0, 8'h02, 0, 0, 1);
        LOAD = 1'b0;
        tick("t4_wrap", 0, 8'hFF, 1, 0, 1);
        tick("t4_after_wrap", 0, 8'hFC, 0, 0, 1);
        SAT = 1'b1; LOAD = 1'b1;
        tick("t4_reload_02", 0, 8'h02, 0, 0, 1);
        LOAD = 1'b0;
        tick("t4_sat", 0, 8'h00, 1, 0, 1);
        tick("t4_sat_hold", 0, 8'h00, 1, 0, 1);
        STEP = 8'd0;
        tick("step0_no_co", 0, 8'h00, 0, 0, 1);
        LIMIT = 8'h00;
        tick("step0_tc", 0, 8'h00, 0, 1, 0);

        // Prescaler = 4, EN gap, START in RUN (checked on u4)
        CLR = 1'b1; DIR = 1'b0; SAT = 1'b0; STEP = 8'd1; LIMIT = 8'hFF;
        tick("t2_reset", 1, 8'd0, 0, 0, 0);
        CLR = 1'b0; START = 1'b1;
        tick("t2_start", 1, 8'd0, 0, 0, 1);
        START = 1'b0;
        tick("t2_p1", 1, 8'd0, 0, 0, 1);
        tick("t2_p2", 1, 8'd0, 0, 0, 1);
        tick("t2_p3", 1, 8'd0, 0, 0, 1);
        tick("t2_step1", 1, 8'd1, 0, 0, 1);
        tick("t2_p1b", 1, 8'd1, 0, 0, 1);
        tick("t2_p2b", 1, 8'd1, 0, 0, 1);
        EN = 1'b0;
        tick("t2_en0_a", 1, 8'd1, 0, 0, 1);
        tick("t2_en0_b", 1, 8'd1, 0, 0, 1);
        tick("t2_en0_c", 1, 8'd1, 0, 0, 1);
        EN = 1'b1;
        tick("t2_p3b", 1, 8'd1, 0, 0, 1);
        tick("t2_step2", 1, 8'd2, 0, 0, 1);
        START = 1'b1;
        tick("t2_start_run_p1", 1, 8'd2, 0, 0, 1);
        START = 1'b0;
        tick("t2_p2c", 1, 8'd2, 0, 0, 1);
        tick("t2_p3c", 1, 8'd2, 0, 0, 1);
        tick("t2_step3", 1, 8'd3, 0, 0, 1);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge CK);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
